time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 25_000_000: Clk cycles per Blink half-period.
REQ-002 SHALL have parameter TIMEOUT, default 500_000_000: idle Clk cycles before an edit session is abandoned.
REQ-003 SHALL have ports, one per line:
- Clk  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Btn_Mode  in  1  debounced level; enter edit / next field.
- Btn_Up  in  1  debounced level; increment field.
- Btn_Down  in  1  debounced level; decrement field.
- Btn_Confirm  in  1  debounced level; commit edited time.
- Mode  in  1  1 = 24-hour, 0 = 12-hour.
- Cur_Hours  in  8  current hours, BCD.
- Cur_Minutes  in  8  current minutes, BCD.
- Cur_Seconds  in  8  current seconds, BCD.
- SET  out  2  load strobe to clock: 00 none, 01 hours, 10 minutes, 11 seconds.
- SETDATA  out  8  BCD value, valid only when SET != 00.
- EN  out  1  clock run enable; 0 while editing or committing.
- Edit_Field  out  2  field under edit: 00 none, 01 H, 10 M, 11 S.
- Blink  out  1  display blink for the edited field.

Function
REQ-004 SHALL rising-edge detect each button; one press = one action regardless of hold length.
REQ-005 SHALL implement states IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT_H, COMMIT_M, COMMIT_S.
REQ-006 IDLE + Mode press SHALL: capture Cur_* into edit registers, latch Mode into session register, go EDIT_H, drive EN=0 from the next cycle.
REQ-007 Capture in 12-hour session SHALL normalise hour: 00->12, 13..23 -> subtract 12 (BCD); 24-hour capture unchanged.
REQ-008 Mode press SHALL cycle EDIT_H->EDIT_M->EDIT_S->EDIT_H.
REQ-009 Up/Down SHALL change the current field by 1 in BCD with wrap: hours 00..23 (24h) or 01..12 (12h); minutes and seconds 00..59.
REQ-010 Wrap points: 23+1=00, 00-1=23, 12+1=01, 01-1=12, 59+1=00, 00-1=59.
REQ-011 Per-cycle priority SHALL be Confirm > Mode > Up/Down; Up and Down edges in the same cycle SHALL be ignored.
REQ-012 Confirm in any EDIT state SHALL go COMMIT_H, COMMIT_M, COMMIT_S on consecutive cycles, driving SET=01/10/11 with SETDATA = edited hour/minute/second; each strobe exactly one cycle.
REQ-013 After COMMIT_S SHALL return to IDLE; EN=1 on the following cycle.
REQ-014 Buttons SHALL be ignored during COMMIT states; Up/Down/Confirm SHALL be ignored in IDLE.
REQ-015 SHALL count idle cycles in EDIT states and reset the count on any accepted edge; reaching TIMEOUT SHALL return to IDLE with no SET strobe and EN=1.
REQ-016 Outside COMMIT states SHALL drive SET=00 and SETDATA=00.
REQ-017 Edit_Field SHALL equal the field of the current EDIT state, else 00.
REQ-018 Blink SHALL toggle every BLINK_HALF cycles in EDIT states, restart high on entry to each field, and be 0 elsewhere.
REQ-019 Changes to Mode input during a session SHALL have no effect until the next session.

Reset
REQ-020 RST=1 SHALL force IDLE, SET=00, SETDATA=00, EN=1, Edit_Field=00, Blink=0, counters 0, edge-detect registers 0, edit registers 00 at the next rising Clk.
REQ-021 RST during COMMIT SHALL abort remaining strobes; no further SET until a new session.
REQ-022 A button held high across RST release SHALL NOT produce an edge.

Verification
REQ-023 Cur=06:55:10, 24h; Mode, Up x2, Confirm -> SET 01/08, 10/55, 11/10 on 3 consecutive cycles, then EN=1.
REQ-024 12h, Cur_Hours=00; Mode, Down -> edit hour 11; capture of Cur_Hours=17 -> 05.
REQ-025 Minutes=59, Mode x2, Up -> 00; Down from 00 -> 59; Up and Down same cycle -> unchanged.
REQ-026 TIMEOUT=100; Mode then no press for 100 cycles -> IDLE, EN=1, SET never non-zero.
REQ-027 RST pulse in COMMIT_M -> SET=00 next cycle, no 11 strobe, EN=1.
REQ-028 Btn_Up held 50 cycles in EDIT_S -> exactly one increment.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-setting controller for a BCD clock. It captures the running time into edit
// registers, lets the user step through the hour, minute and second fields with
// debounced buttons, and on confirm writes the edited values back to the clock
// with three one-cycle load strobes.
module time_set_ctrl #(
  parameter int unsigned BLINK_HALF = 25_000_000,
  parameter int unsigned TIMEOUT    = 500_000_000
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       Btn_Mode,
  input  logic       Btn_Up,
  input  logic       Btn_Down,
  input  logic       Btn_Confirm,
  input  logic       Mode,
  input  logic [7:0] Cur_Hours,
  input  logic [7:0] Cur_Minutes,
  input  logic [7:0] Cur_Seconds,
  output logic [1:0] SET,
  output logic [7:0] SETDATA,
  output logic       EN,
  output logic [1:0] Edit_Field,
  output logic       Blink
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StEditH   = 3'd1;
  localparam logic [2:0] StEditM   = 3'd2;
  localparam logic [2:0] StEditS   = 3'd3;
  localparam logic [2:0] StCommitH = 3'd4;
  localparam logic [2:0] StCommitM = 3'd5;
  localparam logic [2:0] StCommitS = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic          mode_q, mode_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          armed_q;
  logic          mode_prev_q, up_prev_q, down_prev_q, conf_prev_q;

  logic mode_edge, up_edge, down_edge, conf_edge;
  logic up_ok, dn_ok, step_ok, accepted, in_edit, next_edit, timeout_hit;
  logic [7:0] hour_lo, hour_hi;

  // One BCD increment/decrement with wrap between lo and hi.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                          input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] r;
    if (up) begin
      if (v == hi)                r = lo;
      else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
      else                        r = v + 8'd1;
    end else begin
      if (v == lo)                r = hi;
      else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
      else                        r = v - 8'd1;
    end
    return r;
  endfunction

  // Map a 24-hour BCD hour onto the 12-hour range 01..12.
  function automatic logic [7:0] norm12(input logic [7:0] v);
    logic [4:0] bin;
    logic [4:0] b;
    logic [7:0] r;
    bin = 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
    b   = bin - 5'd12;
    if (bin == 5'd0)       r = 8'h12;
    else if (bin > 5'd12)  r = (b < 5'd10) ? {4'd0, b[3:0]} : {4'd1, 4'(b - 5'd10)};
    else                   r = v;
    return r;
  endfunction

  // armed_q masks the first cycle after reset so a button held through reset
  // release is seen as already high rather than as a fresh press.
  assign mode_edge = armed_q & Btn_Mode    & ~mode_prev_q;
  assign up_edge   = armed_q & Btn_Up      & ~up_prev_q;
  assign down_edge = armed_q & Btn_Down    & ~down_prev_q;
  assign conf_edge = armed_q & Btn_Confirm & ~conf_prev_q;

  assign up_ok    = up_edge & ~down_edge;
  assign dn_ok    = down_edge & ~up_edge;
  assign step_ok  = up_ok | dn_ok;
  assign accepted = conf_edge | mode_edge | step_ok;

  assign in_edit     = (state_q == StEditH) || (state_q == StEditM) || (state_q == StEditS);
  assign timeout_hit = in_edit && !accepted && (idle_cnt_q == TW'(TIMEOUT - 1));
  assign hour_lo     = mode_q ? 8'h00 : 8'h01;
  assign hour_hi     = mode_q ? 8'h23 : 8'h12;

  // Next-state: session FSM, field editing, idle timeout and blink timing.
  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    mode_d      = mode_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    case (state_q)
      StIdle: begin
        if (mode_edge) begin
          mode_d  = Mode;
          hour_d  = Mode ? Cur_Hours : norm12(Cur_Hours);
          min_d   = Cur_Minutes;
          sec_d   = Cur_Seconds;
          state_d = StEditH;
        end
      end
      StEditH, StEditM, StEditS: begin
        if (conf_edge) begin
          state_d = StCommitH;
        end else if (mode_edge) begin
          state_d = (state_q == StEditH) ? StEditM :
                    (state_q == StEditM) ? StEditS : StEditH;
        end else if (step_ok) begin
          if (state_q == StEditH)      hour_d = bcd_step(hour_q, up_ok, hour_lo, hour_hi);
          else if (state_q == StEditM) min_d  = bcd_step(min_q, up_ok, 8'h00, 8'h59);
          else                         sec_d  = bcd_step(sec_q, up_ok, 8'h00, 8'h59);
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StCommitH: state_d = StCommitM;
      StCommitM: state_d = StCommitS;
      default:   state_d = StIdle;
    endcase

    idle_cnt_d = (in_edit && !accepted && !timeout_hit) ? idle_cnt_q + TW'(1) : '0;

    next_edit = (state_d == StEditH) || (state_d == StEditM) || (state_d == StEditS);
    if (next_edit && (state_d != state_q)) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (next_edit) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q     <= StIdle;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      mode_q      <= 1'b0;
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      armed_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      conf_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      mode_q      <= mode_d;
      idle_cnt_q  <= idle_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      armed_q     <= 1'b1;
      mode_prev_q <= Btn_Mode;
      up_prev_q   <= Btn_Up;
      down_prev_q <= Btn_Down;
      conf_prev_q <= Btn_Confirm;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    SET        = 2'b00;
    SETDATA    = 8'h00;
    Edit_Field = 2'b00;
    EN         = (state_q == StIdle);
    Blink      = blink_q;
    case (state_q)
      StCommitH: begin SET = 2'b01; SETDATA = hour_q; end
      StCommitM: begin SET = 2'b10; SETDATA = min_q;  end
      StCommitS: begin SET = 2'b11; SETDATA = sec_q;  end
      StEditH:   Edit_Field = 2'b01;
      StEditM:   Edit_Field = 2'b10;
      StEditS:   Edit_Field = 2'b11;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected load strobes are queued by the
// stimulus, a negedge monitor pops and compares each strobe the DUT presents.
module tb_time_set_ctrl;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_CONF = 4'b1000;

  logic       Clk = 1'b0;
  logic       RST;
  logic [3:0] btn;
  logic       Mode;
  logic [7:0] Cur_Hours, Cur_Minutes, Cur_Seconds;
  logic [1:0] SET;
  logic [7:0] SETDATA;
  logic       EN;
  logic [1:0] Edit_Field;
  logic       Blink;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic       prev_strobe = 1'b0;

  time_set_ctrl #(.BLINK_HALF(4), .TIMEOUT(100)) dut (
    .Clk(Clk), .RST(RST),
    .Btn_Mode(btn[0]), .Btn_Up(btn[1]), .Btn_Down(btn[2]), .Btn_Confirm(btn[3]),
    .Mode(Mode), .Cur_Hours(Cur_Hours), .Cur_Minutes(Cur_Minutes),
    .Cur_Seconds(Cur_Seconds), .SET(SET), .SETDATA(SETDATA), .EN(EN),
    .Edit_Field(Edit_Field), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  // Monitor: every non-zero SET must match the head of the queue, and the
  // minute/second strobes must directly follow another strobe.
  always @(negedge Clk) begin
    logic [9:0] e;
    if (SET != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got SET=%b SETDATA=%h want no strobe", SET, SETDATA);
      end else begin
        e = exp_q.pop_front();
        if ({SET, SETDATA} !== e) begin
          errors++;
          $display("FAIL strobe got SET=%b SETDATA=%h want SET=%b SETDATA=%h",
                   SET, SETDATA, e[9:8], e[7:0]);
        end
      end
      if (SET != 2'b01) begin
        checks++;
        if (!prev_strobe) begin
          errors++;
          $display("FAIL strobe_consecutive got gap before SET=%b want back-to-back", SET);
        end
      end
    end
    prev_strobe = (SET != 2'b00);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic press(input logic [3:0] m);
    @(posedge Clk); #1 btn = m;
    @(posedge Clk); #1 btn = 4'b0000;
  endtask

  task automatic expect_commit(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_q.push_back({2'b01, h});
    exp_q.push_back({2'b10, m});
    exp_q.push_back({2'b11, s});
  endtask

  task automatic drain(input string name);
    repeat (6) @(posedge Clk);
    #1 chk(name, 32'(exp_q.size()), 32'd0);
    chk({name, "_en"}, 32'(EN), 32'd1);
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Cur_Hours = h; Cur_Minutes = m; Cur_Seconds = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; btn = 4'b0000; Mode = 1'b1;
    set_cur(8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_set", 32'(SET), 32'd0);
    chk("rst_setdata", 32'(SETDATA), 32'd0);
    chk("rst_en", 32'(EN), 32'd1);
    chk("rst_field", 32'(Edit_Field), 32'd0);
    chk("rst_blink", 32'(Blink), 32'd0);
    RST = 1'b0;

    // 06:55:10 in 24h, two ups on the hour, then confirm.
    set_cur(8'h06, 8'h55, 8'h10);
    press(B_MODE);
    chk("enter_en", 32'(EN), 32'd0);
    chk("enter_field", 32'(Edit_Field), 32'd1);
    chk("enter_blink", 32'(Blink), 32'd1);
    repeat (3) @(posedge Clk);
    #1 chk("blink_hold", 32'(Blink), 32'd1);
    @(posedge Clk);
    #1 chk("blink_toggle", 32'(Blink), 32'd0);
    press(B_UP);
    press(B_UP);
    expect_commit(8'h08, 8'h55, 8'h10);
    press(B_CONF);
    chk("commit_en", 32'(EN), 32'd0);
    repeat (3) @(posedge Clk);
    #1 chk("after_commit_en", 32'(EN), 32'd1);
    drain("t_basic");

    // Confirm/Up in idle do nothing.
    press(B_CONF);
    press(B_UP);
    drain("t_idle_ignore");

    // 12h capture of 00 gives 12, down gives 11.
    Mode = 1'b0;
    set_cur(8'h00, 8'h30, 8'h45);
    press(B_MODE);
    press(B_DOWN);
    expect_commit(8'h11, 8'h30, 8'h45);
    press(B_CONF);
    drain("t_12h_down");

    // 12h capture of 17 gives 05.
    set_cur(8'h17, 8'h01, 8'h02);
    press(B_MODE);
    expect_commit(8'h05, 8'h01, 8'h02);
    press(B_CONF);
    drain("t_12h_norm");

    // 12h session keeps its range even if Mode flips mid-session: 12+1 = 01.
    set_cur(8'h00, 8'h00, 8'h00);
    press(B_MODE);
    Mode = 1'b1;
    press(B_UP);
    expect_commit(8'h01, 8'h00, 8'h00);
    press(B_CONF);
    drain("t_12h_wrap");

    // Minutes 59 + 1 = 00.
    set_cur(8'h12, 8'h59, 8'h00);
    press(B_MODE);
    press(B_MODE);
    chk("field_min", 32'(Edit_Field), 32'd2);
    chk("blink_restart", 32'(Blink), 32'd1);
    press(B_UP);
    expect_commit(8'h12, 8'h00, 8'h00);
    press(B_CONF);
    drain("t_min_up");

    // Up+Down together ignored, then 00 - 1 = 59.
    set_cur(8'h12, 8'h00, 8'h00);
    press(B_MODE);
    press(B_MODE);
    press(B_UP | B_DOWN);
    press(B_DOWN);
    expect_commit(8'h12, 8'h59, 8'h00);
    press(B_CONF);
    drain("t_min_down");

    // Hour 23 + 1 = 00, then Confirm beats Mode in the same cycle.
    set_cur(8'h23, 8'h00, 8'h00);
    press(B_MODE);
    press(B_UP);
    expect_commit(8'h00, 8'h00, 8'h00);
    press(B_CONF | B_MODE);
    drain("t_prio");

    // Timeout after 100 idle cycles with no strobe.
    press(B_MODE);
    repeat (98) @(posedge Clk);
    #1 chk("timeout_early", 32'(EN), 32'd0);
    repeat (2) @(posedge Clk);
    #1 chk("timeout_en", 32'(EN), 32'd1);
    chk("timeout_field", 32'(Edit_Field), 32'd0);
    drain("t_timeout");

    // Reset during COMMIT_M aborts the seconds strobe.
    set_cur(8'h04, 8'h05, 8'h06);
    press(B_MODE);
    exp_q.push_back({2'b01, 8'h04});
    exp_q.push_back({2'b10, 8'h05});
    press(B_CONF);
    @(posedge Clk);
    #1 RST = 1'b1;
    @(posedge Clk);
    #1 RST = 1'b0;
    chk("rst_commit_set", 32'(SET), 32'd0);
    chk("rst_commit_en", 32'(EN), 32'd1);
    drain("t_rst_commit");

    // Mode held across reset release is not a press.
    RST = 1'b1; btn = B_MODE;
    repeat (2) @(posedge Clk);
    #1 RST = 1'b0;
    repeat (4) @(posedge Clk);
    #1 chk("held_rst_en", 32'(EN), 32'd1);
    chk("held_rst_field", 32'(Edit_Field), 32'd0);
    btn = 4'b0000;
    drain("t_held_rst");

    // Up held 50 cycles in EDIT_S gives one increment.
    set_cur(8'h10, 8'h20, 8'h30);
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    chk("field_sec", 32'(Edit_Field), 32'd3);
    @(posedge Clk);
    #1 btn = B_UP;
    repeat (50) @(posedge Clk);
    #1 btn = 4'b0000;
    expect_commit(8'h10, 8'h20, 8'h31);
    press(B_CONF);
    drain("t_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
